// File: rtl/command_issuer.sv
// command_issuer
//   Picks the read or write pool head, then issues the PRE/ACT/RD/WR commands
//   for it to the DRAM interface. It tracks the open row of each bank, and it
//   enforces tRP, tRCD and read/write turnaround with one shared down-counter.
//
//   Optional feature (macro STARVATION_GUARD_EN): each direction has a skip
//   counter. A direction that has lost MAX_SKIP selections while valid wins
//   the next selection unconditionally.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   read_valid / write_valid      pool non-empty flags
//   read_row / write_row    [2:0] head-of-pool row
//   read_bank / write_bank  [1:0] head-of-pool bank
//   read_priority / write_priority [1:0] class from timing_control (lower wins)
//   read_pop / write_pop          one-cycle dequeue pulse, asserted in the access cycle
//   read_issued / write_issued    one-cycle pulse, same cycle as the RD/WR command
//   last_row [2:0], last_bank [1:0]  address of the most recent RD/WR
//   cmd [2:0]                     0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
//   cmd_row [2:0], cmd_bank [1:0] command address (0 when unused)
//   busy                          high whenever the FSM is not idle
module command_issuer #(
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_RCD    = 3,
  parameter int unsigned T_TURN   = 2,
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_valid,
  input  logic       write_valid,
  input  logic [2:0] read_row,
  input  logic [2:0] write_row,
  input  logic [1:0] read_bank,
  input  logic [1:0] write_bank,
  input  logic [1:0] read_priority,
  input  logic [1:0] write_priority,
  output logic       read_pop,
  output logic       write_pop,
  output logic       read_issued,
  output logic       write_issued,
  output logic [2:0] last_row,
  output logic [1:0] last_bank,
  output logic [2:0] cmd,
  output logic [2:0] cmd_row,
  output logic [1:0] cmd_bank,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_TURN_WAIT,
    S_ACCESS
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  // Timing values must be at least 1, and the skip limit must fit in 3 bits.
  if (T_RP < 1 || T_RCD < 1 || T_TURN < 1 || MAX_SKIP < 1 || MAX_SKIP > 7) begin : g_param_check
    $error("command_issuer: illegal parameter value");
  end

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;

  logic [2:0] req_row;
  logic [1:0] req_bank;
  logic       req_rd;       // 1 = read, 0 = write
  logic       last_we;      // direction of the last access, same encoding as req_rd

  logic [3:0] bank_open;
  logic [2:0] open_row [4];

  logic       any_valid;
  logic       sel_rd;
  logic [2:0] sel_row;
  logic [1:0] sel_bank;

`ifdef STARVATION_GUARD_EN
  localparam logic [2:0] SKIP_LIMIT = 3'(MAX_SKIP);
  logic [2:0] rd_skip, wr_skip;
`endif

  // Direction selection. This result is only used while the FSM is in IDLE.
  always_comb begin
    any_valid = read_valid | write_valid;
    sel_rd    = 1'b0;
    if (read_valid && !write_valid) begin
      sel_rd = 1'b1;
    end else if (read_valid && write_valid) begin
`ifdef STARVATION_GUARD_EN
      if (rd_skip >= SKIP_LIMIT) sel_rd = 1'b1;
      else if (wr_skip >= SKIP_LIMIT) sel_rd = 1'b0;
      else
`endif
      if (read_priority < write_priority) sel_rd = 1'b1;
      else if (read_priority == write_priority) sel_rd = last_we;
    end
    sel_row  = sel_rd ? read_row  : write_row;
    sel_bank = sel_rd ? read_bank : write_bank;
  end

  // Next state, counter load/decrement, Moore output decode.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    cmd          = CMD_NOP;
    cmd_row      = '0;
    cmd_bank     = '0;
    read_pop     = 1'b0;
    write_pop    = 1'b0;
    read_issued  = 1'b0;
    write_issued = 1'b0;
    busy         = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (any_valid) begin
          if (bank_open[sel_bank]) begin
            if (open_row[sel_bank] == sel_row) begin
              if (sel_rd == last_we) begin
                state_next = S_ACCESS;
              end else begin
                state_next = S_TURN_WAIT;
                cnt_next   = 8'(T_TURN);
              end
            end else begin
              state_next = S_PRE;
            end
          end else begin
            state_next = S_ACT;
          end
        end
      end
      S_PRE: begin
        cmd        = CMD_PRE;
        cmd_bank   = req_bank;
        state_next = S_PRE_WAIT;
        cnt_next   = 8'(T_RP);
      end
      S_PRE_WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt <= 8'd1) state_next = S_ACT;
      end
      S_ACT: begin
        cmd        = CMD_ACT;
        cmd_row    = req_row;
        cmd_bank   = req_bank;
        state_next = S_ACT_WAIT;
        cnt_next   = 8'(T_RCD);
      end
      S_ACT_WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          if (req_rd != last_we) begin
            state_next = S_TURN_WAIT;
            cnt_next   = 8'(T_TURN);
          end else begin
            state_next = S_ACCESS;
          end
        end
      end
      S_TURN_WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt <= 8'd1) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        cmd          = req_rd ? CMD_RD : CMD_WR;
        cmd_row      = req_row;
        cmd_bank     = req_bank;
        read_pop     = req_rd;
        write_pop    = ~req_rd;
        read_issued  = req_rd;
        write_issued = ~req_rd;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_row   <= '0;
      req_bank  <= '0;
      req_rd    <= 1'b0;
      last_we   <= 1'b0;
      last_row  <= '0;
      last_bank <= '0;
      bank_open <= '0;
      for (int unsigned i = 0; i < 4; i++) open_row[i] <= '0;
`ifdef STARVATION_GUARD_EN
      rd_skip   <= '0;
      wr_skip   <= '0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;

      if (state == S_IDLE && any_valid) begin
        req_row  <= sel_row;
        req_bank <= sel_bank;
        req_rd   <= sel_rd;
`ifdef STARVATION_GUARD_EN
        if (sel_rd)           rd_skip <= '0;
        else if (read_valid)  rd_skip <= rd_skip + 3'd1;
        if (!sel_rd)          wr_skip <= '0;
        else if (write_valid) wr_skip <= wr_skip + 3'd1;
`endif
      end

      if (state == S_PRE) bank_open[req_bank] <= 1'b0;

      if (state == S_ACT) begin
        bank_open[req_bank] <= 1'b1;
        open_row[req_bank]  <= req_row;
      end

      if (state == S_ACCESS) begin
        last_row  <= req_row;
        last_bank <= req_bank;
        last_we   <= req_rd;
      end
    end
  end

endmodule
